// File: rtl/uart_char_led_if.sv
// Serial input plus received-byte, error and LED outputs of uart_char_led_ctrl.
// The slave side is the controller; the master side drives the line and observes.
interface uart_char_led_if;
    logic       UART_RXD;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       FRAME_ERR;
    logic       LED0;
    logic       LED1;

    modport master (
        output UART_RXD,
        input  RX_DATA, RX_VALID, FRAME_ERR, LED0, LED1
    );

    modport slave (
        input  UART_RXD,
        output RX_DATA, RX_VALID, FRAME_ERR, LED0, LED1
    );
endinterface

// File: rtl/uart_char_led_ctrl.sv
// 8N1 UART receiver (16x oversampled) decoding single-character LED commands.
// Two LEDs run OFF / ON / BLINK from one free-running shared blink phase.
module uart_char_led_ctrl #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned BLINK_HALF = 12500000
) (
    input  logic             FAB_CCC_GL0,
    input  logic             FAB_RESET_N,
    uart_char_led_if.slave   bus
);
    localparam int unsigned DIV_RAW = CLK_HZ / (BAUD * 16);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BL_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;

    logic [1:0]       r_sync;
    logic [DIV_W-1:0] r_div_cnt;
    logic [1:0]       r_state, w_state;
    logic [3:0]       r_tc, w_tc;
    logic [2:0]       r_bi, w_bi;
    logic [7:0]       r_shift, w_shift;
    logic             r_armed, w_armed;
    logic [7:0]       r_rx_data, w_rx_data;
    logic             r_rx_valid, w_rx_valid;
    logic             r_frame_err, w_frame_err;
    logic [1:0]       r_mode0, r_mode1;
    logic [BL_W-1:0]  r_bl_cnt;
    logic             r_phase;
    logic             r_led0, r_led1;
    logic             w_rxd;
    logic             w_tick;
    logic             w_bl_wrap;

    assign w_rxd     = r_sync[1];
    assign w_tick    = (r_div_cnt == DIV_W'(DIV - 1));
    assign w_bl_wrap = (r_bl_cnt == BL_W'(BLINK_HALF - 1));

    // Input synchronizer and free-running 16x baud tick
    always_ff @(posedge FAB_CCC_GL0) begin
        if (!FAB_RESET_N) begin
            r_sync    <= 2'b11;
            r_div_cnt <= '0;
        end else begin
            r_sync    <= {r_sync[0], bus.UART_RXD};
            r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge FAB_CCC_GL0) begin
        if (!FAB_RESET_N) begin
            r_state     <= ST_IDLE;
            r_tc        <= '0;
            r_bi        <= '0;
            r_shift     <= '0;
            r_armed     <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_tc        <= w_tc;
            r_bi        <= w_bi;
            r_shift     <= w_shift;
            r_armed     <= w_armed;
            r_rx_data   <= w_rx_data;
            r_rx_valid  <= w_rx_valid;
            r_frame_err <= w_frame_err;
        end
    end

    // IDLE only arms after seeing the line high, so a stuck-low line cannot retrigger
    always_comb begin
        w_state     = r_state;
        w_tc        = r_tc;
        w_bi        = r_bi;
        w_shift     = r_shift;
        w_armed     = r_armed;
        w_rx_data   = r_rx_data;
        w_rx_valid  = 1'b0;
        w_frame_err = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_armed) begin
                    w_armed = w_rxd;
                end else if (!w_rxd) begin
                    w_state = ST_START;
                    w_tc    = '0;
                    w_armed = 1'b0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (r_tc == 4'd7) begin
                        w_tc = '0;
                        w_bi = '0;
                        w_state = w_rxd ? ST_IDLE : ST_DATA;
                    end else begin
                        w_tc = r_tc + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_tc == 4'd15) begin
                        w_shift[r_bi] = w_rxd;
                        w_tc = '0;
                        if (r_bi == 3'd7) w_state = ST_STOP;
                        else              w_bi = r_bi + 3'd1;
                    end else begin
                        w_tc = r_tc + 4'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_tc == 4'd15) begin
                        w_tc    = '0;
                        w_state = ST_IDLE;
                        if (w_rxd) begin
                            w_rx_data  = r_shift;
                            w_rx_valid = 1'b1;
                        end else begin
                            w_frame_err = 1'b1;
                        end
                    end else begin
                        w_tc = r_tc + 4'd1;
                    end
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    function automatic logic led_of(input logic [1:0] mode, input logic phase);
        case (mode)
            MODE_ON:    led_of = 1'b1;
            MODE_BLINK: led_of = phase;
            default:    led_of = 1'b0;
        endcase
    endfunction

    // Command decode on the registered byte, then blink phase and LED drive
    always_ff @(posedge FAB_CCC_GL0) begin
        if (!FAB_RESET_N) begin
            r_mode0  <= MODE_OFF;
            r_mode1  <= MODE_OFF;
            r_bl_cnt <= '0;
            r_phase  <= 1'b0;
            r_led0   <= 1'b0;
            r_led1   <= 1'b0;
        end else begin
            if (r_rx_valid) begin
                case (r_rx_data)
                    8'h30: r_mode0 <= MODE_OFF;
                    8'h31: r_mode0 <= MODE_ON;
                    8'h32: r_mode0 <= MODE_BLINK;
                    8'h33: r_mode1 <= MODE_OFF;
                    8'h34: r_mode1 <= MODE_ON;
                    8'h35: r_mode1 <= MODE_BLINK;
                    8'h78: begin
                        r_mode0 <= MODE_OFF;
                        r_mode1 <= MODE_OFF;
                    end
                    default: ;
                endcase
            end
            r_bl_cnt <= w_bl_wrap ? '0 : r_bl_cnt + BL_W'(1);
            if (w_bl_wrap) r_phase <= ~r_phase;
            r_led0 <= led_of(r_mode0, r_phase);
            r_led1 <= led_of(r_mode1, r_phase);
        end
    end

    assign bus.RX_DATA   = r_rx_data;
    assign bus.RX_VALID  = r_rx_valid;
    assign bus.FRAME_ERR = r_frame_err;
    assign bus.LED0      = r_led0;
    assign bus.LED1      = r_led1;
endmodule

// File: tb/tb_uart_char_led_ctrl.sv
// Scoreboarded bench for uart_char_led_ctrl: frames queue their expected result,
// a negedge monitor checks every pulse, and an LED model predicts both outputs.
module tb_uart_char_led_ctrl;
    localparam int unsigned CLK_HZ     = 1600000;
    localparam int unsigned BAUD       = 10000;
    localparam int unsigned BLINK_HALF = 8;
    localparam int          BIT_CYC    = 160;
    localparam int          LAT_MIN    = 1500;
    localparam int          LAT_MAX    = 1620;

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         start;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_char_led_if bus ();

    uart_char_led_ctrl #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .BLINK_HALF(BLINK_HALF)
    ) u_dut (
        .FAB_CCC_GL0(clk),
        .FAB_RESET_N(rst_n),
        .bus        (bus)
    );

    exp_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         edge_cnt = 0;
    int         n_valid = 0;
    int         n_ferr = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] last_data = 8'h00;
    int         m0 = 0;
    int         m1 = 0;
    logic [7:0] cmds[7] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h78};
    logic [7:0] seq[5]  = '{8'h31, 8'h35, 8'h32, 8'h78, 8'h41};

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Edges since reset release; blink phase follows from this count alone
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        edge_cnt <= rst_n ? edge_cnt + 1 : 0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            last_data  = 8'h00;
            prev_valid = 1'b0;
        end else if (bus.RX_VALID || bus.FRAME_ERR) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: valid=%0b ferr=%0b data=0x%0h expected none",
                         bus.RX_VALID, bus.FRAME_ERR, bus.RX_DATA);
            end else begin
                exp_t e;
                int   lat;
                e   = exp_q.pop_front();
                lat = cyc - e.start;
                if (e.err) begin
                    n_ferr++;
                    chk("ferr_flag", int'(bus.FRAME_ERR), 1);
                    chk("ferr_no_valid", int'(bus.RX_VALID), 0);
                    chk("ferr_data_kept", int'(bus.RX_DATA), int'(last_data));
                end else begin
                    n_valid++;
                    chk("valid_flag", int'(bus.RX_VALID), 1);
                    chk("valid_no_ferr", int'(bus.FRAME_ERR), 0);
                    chk("rx_data", int'(bus.RX_DATA), int'(e.data));
                    chk("valid_width", int'(prev_valid), 0);
                    total++;
                    if (lat < LAT_MIN || lat > LAT_MAX) begin
                        bad++;
                        $display("FAIL rx_latency: got %0d cycles expected %0d..%0d",
                                 lat, LAT_MIN, LAT_MAX);
                    end
                    last_data = e.data;
                end
            end
        end
        prev_valid = bus.RX_VALID;
    end

    function automatic int exp_led(input int mode, input int c);
        if (mode == 0) return 0;
        if (mode == 1) return 1;
        return ((c - 1) / int'(BLINK_HALF)) % 2;
    endfunction

    task automatic apply_cmd(input logic [7:0] d);
        case (d)
            8'h30: m0 = 0;
            8'h31: m0 = 1;
            8'h32: m0 = 2;
            8'h33: m1 = 0;
            8'h34: m1 = 1;
            8'h35: m1 = 2;
            8'h78: begin m0 = 0; m1 = 0; end
            default: ;
        endcase
    endtask

    task automatic check_leds(input int n);
        repeat (n) begin
            chk("led0", int'(bus.LED0), exp_led(m0, edge_cnt));
            chk("led1", int'(bus.LED1), exp_led(m1, edge_cnt));
            @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        exp_t e;
        e.err   = ~stop;
        e.data  = d;
        e.start = cyc;
        exp_q.push_back(e);
        bus.UART_RXD = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.UART_RXD = d[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        bus.UART_RXD = stop;
        repeat (BIT_CYC) @(negedge clk);
        bus.UART_RXD = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_data"}, int'(bus.RX_DATA), 0);
        chk({tag, "_rx_valid"}, int'(bus.RX_VALID), 0);
        chk({tag, "_frame_err"}, int'(bus.FRAME_ERR), 0);
        chk({tag, "_led0"}, int'(bus.LED0), 0);
        chk({tag, "_led1"}, int'(bus.LED1), 0);
    endtask

    initial begin
        int         nv;
        int         nf;
        logic [7:0] d;
        logic       stop;

        bus.UART_RXD = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        repeat (2000) @(negedge clk);
        chk("idle_no_valid", n_valid, 0);
        chk("idle_no_ferr", n_ferr, 0);

        send_byte(8'hA5, 1'b1);
        repeat (20) @(negedge clk);
        chk("a5_count", n_valid, 1);
        chk("a5_data", int'(bus.RX_DATA), 8'hA5);
        apply_cmd(8'hA5);

        send_byte(8'h31, 1'b0);
        repeat (200) @(negedge clk);
        chk("fe_count", n_ferr, 1);
        chk("fe_no_valid", n_valid, 1);
        chk("fe_data_kept", int'(bus.RX_DATA), 8'hA5);
        check_leds(4);

        bus.UART_RXD = 1'b0;
        repeat (40) @(negedge clk);
        bus.UART_RXD = 1'b1;
        repeat (400) @(negedge clk);
        chk("glitch_no_valid", n_valid, 1);
        chk("glitch_no_ferr", n_ferr, 1);
        send_byte(8'h55, 1'b1);
        repeat (20) @(negedge clk);
        chk("after_glitch_count", n_valid, 2);
        chk("after_glitch_data", int'(bus.RX_DATA), 8'h55);

        foreach (seq[k]) begin
            send_byte(seq[k], 1'b1);
            repeat (10) @(negedge clk);
            apply_cmd(seq[k]);
            check_leds(24);
        end

        nv = n_valid;
        send_byte(8'h30, 1'b1);
        send_byte(8'h34, 1'b1);
        repeat (10) @(negedge clk);
        apply_cmd(8'h30);
        apply_cmd(8'h34);
        chk("b2b_count", n_valid - nv, 2);
        chk("b2b_led0", int'(bus.LED0), 0);
        chk("b2b_led1", int'(bus.LED1), 1);
        check_leds(8);

        nv = n_valid;
        nf = n_ferr;
        bus.UART_RXD = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus.UART_RXD = (i != 1);
            repeat (BIT_CYC) @(negedge clk);
        end
        rst_n = 1'b0;
        bus.UART_RXD = 1'b1;
        m0 = 0;
        m1 = 0;
        repeat (5) @(negedge clk);
        check_reset_outputs("abort");
        rst_n = 1'b1;
        repeat (2000) @(negedge clk);
        chk("abort_no_valid", n_valid - nv, 0);
        chk("abort_no_ferr", n_ferr - nf, 0);
        check_reset_outputs("post_abort");

        for (int r = 0; r < 10; r++) begin
            if ($urandom_range(0, 8) <= 6) d = cmds[$urandom_range(0, 6)];
            else                           d = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            send_byte(d, stop);
            repeat (10) @(negedge clk);
            if (stop) apply_cmd(d);
            check_leds(8);
            repeat ($urandom_range(0, 300)) @(negedge clk);
        end

        repeat (50) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
